// File: rtl/mac_stop_ctrl.sv
// mac_stop_ctrl: sequences an SRAM-backed C = A x B multiply-accumulate with synchronous abort
// Ports: clk / resetn (async active-low); start begins a multiply from IDLE, stop aborts RUN/WRITE;
//   busy high in RUN and WRITE, done pulses once after the last C write;
//   A/B read addresses and read enables, data_out_a/b are combinational read data;
//   C write address, write enable and data_in_c (the accumulator).
module mac_stop_ctrl #(
   parameter int M = 4,
   parameter int K = 4,
   parameter int N = 4,
   parameter int DATA_WIDTH_INIT_MATRIX = 32,
   parameter int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX + $clog2(K)
) (
   input  logic                                clk,
   input  logic                                resetn,
   input  logic                                start,
   input  logic                                stop,
   output logic                                busy,
   output logic                                done,
   output logic [$clog2(M)-1:0]                row_addr_a,
   output logic [$clog2(M)-1:0]                row_addr_c,
   output logic [$clog2(K)-1:0]                col_addr_a,
   output logic [$clog2(K)-1:0]                row_addr_b,
   output logic [$clog2(N)-1:0]                col_addr_b,
   output logic [$clog2(N)-1:0]                col_addr_c,
   output logic                                matrix_a_re,
   output logic                                matrix_b_re,
   output logic                                matrix_c_we,
   input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_a,
   input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_b,
   output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c
);
   localparam int AW = DATA_WIDTH_INIT_MATRIX;
   localparam int RW = DATA_WIDTH_RESULT_MATRIX;
   localparam int MW = $clog2(M);
   localparam int KW = $clog2(K);
   localparam int NW = $clog2(N);
   localparam logic [MW-1:0] M_LAST = MW'(M - 1);
   localparam logic [KW-1:0] K_LAST = KW'(K - 1);
   localparam logic [NW-1:0] N_LAST = NW'(N - 1);
   typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_t;
   state_t state_q, state_d;
   logic [MW-1:0] i_q, i_d;
   logic [KW-1:0] k_q, k_d;
   logic [NW-1:0] j_q, j_d;
   logic [RW-1:0] acc_q, acc_d;
   logic [2*AW-1:0] prod;
   logic busy_q, busy_d, done_q, done_d, re_q, re_d, we_q, we_d;
   always_comb begin
      prod = {{AW{1'b0}}, data_out_a} * {{AW{1'b0}}, data_out_b};
      state_d = state_q;
      i_d = i_q;
      j_d = j_q;
      k_d = k_q;
      acc_d = acc_q;
      case (state_q)
         IDLE: begin
            state_d = start ? RUN : IDLE;
         end
         RUN: begin
            // k = 0 restarts the sum so no separate clear cycle is needed
            acc_d = (k_q == '0 ? '0 : acc_q) + RW'(prod);
            k_d = k_q == K_LAST ? '0 : k_q + 1'b1;
            state_d = stop ? IDLE : (k_q == K_LAST ? WRITE : RUN);
         end
         WRITE: begin
            j_d = j_q == N_LAST ? '0 : j_q + 1'b1;
            i_d = j_q == N_LAST ? i_q + 1'b1 : i_q;
            state_d = stop ? IDLE : (i_q == M_LAST && j_q == N_LAST ? DONE : RUN);
         end
         default: state_d = IDLE;
      endcase
      // indices rest at zero outside RUN/WRITE so IDLE and DONE drive address 0
      if (state_d == IDLE || state_d == DONE) begin
         i_d = '0;
         j_d = '0;
         k_d = '0;
      end
      busy_d = state_d == RUN || state_d == WRITE;
      done_d = state_d == DONE;
      re_d = state_d == RUN;
      we_d = state_d == WRITE;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         i_q <= '0;
         j_q <= '0;
         k_q <= '0;
         acc_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         re_q <= 1'b0;
         we_q <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q <= i_d;
         j_q <= j_d;
         k_q <= k_d;
         acc_q <= acc_d;
         busy_q <= busy_d;
         done_q <= done_d;
         re_q <= re_d;
         we_q <= we_d;
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign matrix_a_re = re_q;
   assign matrix_b_re = re_q;
   assign matrix_c_we = we_q;
   assign row_addr_a = i_q;
   assign row_addr_c = i_q;
   assign col_addr_a = k_q;
   assign row_addr_b = k_q;
   assign col_addr_b = j_q;
   assign col_addr_c = j_q;
   assign data_in_c = acc_q;
endmodule

// File: tb/tb_mac_stop_ctrl.sv
// tb_mac_stop_ctrl: scoreboard bench for mac_stop_ctrl with a behavioural A/B/C SRAM
module tb_mac_stop_ctrl;
   localparam int M = 3;
   localparam int K = 4;
   localparam int N = 2;
   localparam int W = 8;
   localparam int RW = 2*W + $clog2(K);
   localparam int BUSY_CYC = M*N*(K+1);
   logic clk = 1'b0;
   logic resetn, start, stop, clr_c;
   logic busy, done, matrix_a_re, matrix_b_re, matrix_c_we;
   logic [$clog2(M)-1:0] row_addr_a, row_addr_c;
   logic [$clog2(K)-1:0] col_addr_a, row_addr_b;
   logic [$clog2(N)-1:0] col_addr_b, col_addr_c;
   logic [W-1:0] data_out_a, data_out_b;
   logic [RW-1:0] data_in_c;
   logic [W-1:0] a_mem [M][K];
   logic [W-1:0] b_mem [K][N];
   logic [RW-1:0] c_mem [M][N];
   int exp_c [M][N];
   typedef struct {int i; int j; longint v;} wr_t;
   wr_t q[$];
   int checks = 0;
   int errors = 0;
   int nb, dc, nd;
   always #5 clk = ~clk;
   mac_stop_ctrl #(.M(M), .K(K), .N(N), .DATA_WIDTH_INIT_MATRIX(W)) dut (
      .clk(clk), .resetn(resetn), .start(start), .stop(stop), .busy(busy), .done(done),
      .row_addr_a(row_addr_a), .row_addr_c(row_addr_c), .col_addr_a(col_addr_a),
      .row_addr_b(row_addr_b), .col_addr_b(col_addr_b), .col_addr_c(col_addr_c),
      .matrix_a_re(matrix_a_re), .matrix_b_re(matrix_b_re), .matrix_c_we(matrix_c_we),
      .data_out_a(data_out_a), .data_out_b(data_out_b), .data_in_c(data_in_c)
   );
   assign data_out_a = a_mem[row_addr_a][col_addr_a];
   assign data_out_b = b_mem[row_addr_b][col_addr_b];
   always @(posedge clk) begin
      if (clr_c) begin
         for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
               c_mem[i][j] <= '0;
      end else if (matrix_c_we) c_mem[row_addr_c][col_addr_c] <= data_in_c;
   end
   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask
   always @(negedge clk) begin
      wr_t e;
      if (resetn && matrix_c_we) begin
         chk("wr_pending", longint'(q.size() > 0), 1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("wr_row", longint'(row_addr_c), e.i);
            chk("wr_col", longint'(col_addr_c), e.j);
            chk("wr_data", longint'(data_in_c), e.v);
         end
      end
   end
   task automatic chk_zero(input string nm);
      chk(nm, longint'({busy, done, matrix_a_re, matrix_b_re, matrix_c_we, row_addr_a, row_addr_c,
                        col_addr_a, row_addr_b, col_addr_b, col_addr_c, data_in_c}), 0);
   endtask
   task automatic clear_c();
      clr_c = 1'b1;
      @(negedge clk);
      clr_c = 1'b0;
   endtask
   task automatic push_n(input int cnt);
      for (int e = 0; e < cnt; e++) q.push_back('{e / N, e % N, longint'(exp_c[e / N][e % N])});
   endtask
   task automatic run(input int stop_at, input int restart_at, input int rst_at);
      nb = 0;
      dc = 0;
      nd = 0;
      @(negedge clk);
      start = 1'b1;
      for (int t = 1; t <= BUSY_CYC + 10; t++) begin
         @(negedge clk);
         if (busy) nb++;
         if (done) begin
            nd++;
            if (dc == 0) dc = t;
         end
         if (stop_at != 0 && t == stop_at + 1) chk("stop_idle", longint'({busy, matrix_a_re, matrix_c_we}), 0);
         start = (t == restart_at);
         stop = (t == stop_at);
         if (t == rst_at) begin
            chk("mid_busy", longint'(busy), 1);
            resetn = 1'b0;
            #1;
            chk_zero("reset_mid_outputs");
            @(negedge clk);
            resetn = 1'b1;
            q.delete();
            break;
         end
      end
      start = 1'b0;
      stop = 1'b0;
   endtask
   task automatic check_full(input string nm);
      chk({nm, "_busy_cycles"}, nb, BUSY_CYC);
      chk({nm, "_done_cycle"}, dc, BUSY_CYC + 1);
      chk({nm, "_done_pulses"}, nd, 1);
      chk({nm, "_writes_left"}, q.size(), 0);
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++)
            chk($sformatf("%s_c%0d%0d", nm, i, j), longint'(c_mem[i][j]), exp_c[i][j]);
   endtask
   task automatic load_basic();
      a_mem = '{'{1, 2, 0, 0}, '{3, 4, 0, 0}, '{0, 0, 1, 1}};
      b_mem = '{'{5, 6}, '{7, 8}, '{2, 3}, '{4, 1}};
      exp_c = '{'{19, 22}, '{43, 50}, '{6, 4}};
   endtask
   task automatic load_ident();
      a_mem = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 1, 0}};
      b_mem = '{'{1, 2}, '{3, 4}, '{5, 6}, '{7, 8}};
      exp_c = '{'{1, 2}, '{3, 4}, '{5, 6}};
   endtask
   task automatic load_max();
      for (int i = 0; i < M; i++)
         for (int k = 0; k < K; k++)
            a_mem[i][k] = 8'd255;
      for (int k = 0; k < K; k++)
         for (int j = 0; j < N; j++)
            b_mem[k][j] = 8'd255;
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++)
            exp_c[i][j] = 260100;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      resetn = 1'b0;
      start = 1'b0;
      stop = 1'b0;
      clr_c = 1'b0;
      load_basic();
      repeat (2) @(negedge clk);
      chk_zero("reset_outputs");
      resetn = 1'b1;
      clear_c();
      push_n(M*N);
      run(0, 0, 0);
      check_full("basic");
      load_ident();
      clear_c();
      push_n(M*N);
      run(0, 0, 0);
      check_full("ident");
      load_max();
      clear_c();
      push_n(M*N);
      run(0, 0, 0);
      check_full("max");
      load_basic();
      clear_c();
      push_n(3);
      run(3*(K+1) + 3, 0, 0);
      chk("stop_done_pulses", nd, 0);
      chk("stop_writes_left", q.size(), 0);
      chk("stop_c00", longint'(c_mem[0][0]), 19);
      chk("stop_c01", longint'(c_mem[0][1]), 22);
      chk("stop_c10", longint'(c_mem[1][0]), 43);
      chk("stop_c11", longint'(c_mem[1][1]), 0);
      chk("stop_c20", longint'(c_mem[2][0]), 0);
      chk("stop_c21", longint'(c_mem[2][1]), 0);
      load_ident();
      clear_c();
      push_n(M*N);
      run(0, K+1, 0);
      check_full("restart_in_write");
      clear_c();
      push_n(M*N);
      run(0, 0, 0);
      check_full("rerun");
      load_max();
      clear_c();
      push_n(M*N);
      run(0, 0, 8);
      repeat (BUSY_CYC) @(negedge clk);
      chk_zero("after_reset_idle");
      clear_c();
      push_n(M*N);
      run(0, 0, 0);
      check_full("post_reset");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
